// File: rtl/rsv_pkg.sv
// Shared types and default sizing for the reservation-station lane.
// Entry and source-operand records are laid out at the default widths.
package rsv_pkg;

  localparam int RSV_NUM_ENTRIES = 8;
  localparam int RSV_CDB_LANES   = 2;
  localparam int RSV_NUM_SRCS    = 2;
  localparam int ROB_SIZE        = 32;
  localparam int ROB_SIZE_CLOG   = $clog2(ROB_SIZE);
  localparam int RSV_TAG_W       = ROB_SIZE_CLOG;
  localparam int RSV_DATA_W      = 32;
  localparam int RSV_OP_W        = 6;

  typedef struct packed {
    logic                  rdy;
    logic [RSV_TAG_W-1:0]  tag;
    logic [RSV_DATA_W-1:0] val;
  } rsv_src_t;

  typedef struct packed {
    logic                            valid;
    logic [RSV_OP_W-1:0]             op;
    logic [RSV_TAG_W-1:0]            dst_tag;
    rsv_src_t [RSV_NUM_SRCS-1:0]     src;
  } rsv_entry_t;

endpackage

// File: rtl/rsv_sched_if.sv
// Rename/dispatch, CDB snoop and functional-unit handshake bundle for one lane.
// master drives allocations, broadcasts and the FU ready; slave is the station.
interface rsv_sched_if import rsv_pkg::*; #(
  parameter int NUM_ENTRIES = RSV_NUM_ENTRIES,
  parameter int CDB_LANES   = RSV_CDB_LANES,
  parameter int NUM_SRCS    = RSV_NUM_SRCS,
  parameter int TAG_W       = RSV_TAG_W,
  parameter int DATA_W      = RSV_DATA_W,
  parameter int OP_W        = RSV_OP_W
);
  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  logic                         flush;
  logic                         alloc_val;
  logic                         alloc_rdy;
  logic [OP_W-1:0]              alloc_op;
  logic [TAG_W-1:0]             alloc_dst_tag;
  logic [NUM_SRCS-1:0]          alloc_src_rdy;
  logic [NUM_SRCS*TAG_W-1:0]    alloc_src_tag;
  logic [NUM_SRCS*DATA_W-1:0]   alloc_src_val;
  logic [CDB_LANES-1:0]         cdb_val;
  logic [CDB_LANES*TAG_W-1:0]   cdb_tag;
  logic [CDB_LANES*DATA_W-1:0]  cdb_data;
  logic                         disp_val;
  logic                         disp_rdy;
  logic [OP_W-1:0]              disp_op;
  logic [TAG_W-1:0]             disp_dst_tag;
  logic [NUM_SRCS*DATA_W-1:0]   disp_src;
  logic [CNT_W-1:0]             count;
  logic                         full;
  logic                         empty;

  modport master (
    output flush, alloc_val, alloc_op, alloc_dst_tag, alloc_src_rdy, alloc_src_tag,
           alloc_src_val, cdb_val, cdb_tag, cdb_data, disp_rdy,
    input  alloc_rdy, disp_val, disp_op, disp_dst_tag, disp_src, count, full, empty
  );

  modport slave (
    input  flush, alloc_val, alloc_op, alloc_dst_tag, alloc_src_rdy, alloc_src_tag,
           alloc_src_val, cdb_val, cdb_tag, cdb_data, disp_rdy,
    output alloc_rdy, disp_val, disp_op, disp_dst_tag, disp_src, count, full, empty
  );

endinterface

// File: rtl/rsv_age_sel.sv
// Age matrix over the station slots: remembers allocation order and grants
// the oldest ready entry regardless of which slot it happens to occupy.
module rsv_age_sel import rsv_pkg::*; #(
  parameter int NUM_ENTRIES = RSV_NUM_ENTRIES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [NUM_ENTRIES-1:0] alloc_oh,
  input  logic [NUM_ENTRIES-1:0] disp_oh,
  input  logic [NUM_ENTRIES-1:0] ready,
  output logic [NUM_ENTRIES-1:0] grant
);

  // older_q[i][j] set means slot j holds an entry allocated before slot i's entry
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [NUM_ENTRIES-1:0] valid_d;

  always_comb begin
    valid_d = (valid_q & ~disp_oh) | alloc_oh;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      older_d[i] = older_q[i] & ~disp_oh & ~alloc_oh;
      if (alloc_oh[i]) begin
        older_d[i] = valid_q & ~disp_oh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        older_q[i] <= older_d[i];
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      grant[i] = ready[i] & ~(|(older_q[i] & ready));
    end
  end

endmodule

// File: rtl/rsv_sched.sv
// Reservation station for one execution lane: allocates renamed instructions,
// wakes sources from the CDB and issues the oldest ready entry to the FU.
module rsv_sched import rsv_pkg::*; #(
  parameter int NUM_ENTRIES = RSV_NUM_ENTRIES,
  parameter int CDB_LANES   = RSV_CDB_LANES,
  parameter int NUM_SRCS    = RSV_NUM_SRCS,
  parameter int TAG_W       = RSV_TAG_W,
  parameter int DATA_W      = RSV_DATA_W,
  parameter int OP_W        = RSV_OP_W
) (
  input logic        clk,
  input logic        rst,
  rsv_sched_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

  rsv_entry_t             ent_q [NUM_ENTRIES];
  rsv_entry_t             ent_d [NUM_ENTRIES];
  rsv_src_t               alloc_src [NUM_SRCS];
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;
  logic                   full_q;
  logic                   empty_q;
  logic [NUM_ENTRIES-1:0] valid_vec;
  logic [NUM_ENTRIES-1:0] ready_vec;
  logic [NUM_ENTRIES-1:0] free_oh;
  logic [NUM_ENTRIES-1:0] alloc_oh;
  logic [NUM_ENTRIES-1:0] disp_oh;
  logic [NUM_ENTRIES-1:0] grant;
  logic                   free_found;
  logic                   alloc_fire;
  logic                   disp_fire;
  logic                   cdb_dup;
  logic [CDB_LANES-1:0]   cdb_val;
  logic [TAG_W-1:0]       cdb_tag  [CDB_LANES];
  logic [DATA_W-1:0]      cdb_data [CDB_LANES];
  logic [OP_W-1:0]        sel_op;
  logic [TAG_W-1:0]       sel_dst;
  logic [NUM_SRCS*DATA_W-1:0] sel_src;

  always_comb begin
    cdb_val = bus.cdb_val;
    for (int l = 0; l < CDB_LANES; l++) begin
      cdb_tag[l]  = bus.cdb_tag[l*TAG_W +: TAG_W];
      cdb_data[l] = bus.cdb_data[l*DATA_W +: DATA_W];
    end
  end

  // A waiting source captures data from the lowest-index matching lane.
  function automatic rsv_src_t snoop(input rsv_src_t s_in);
    rsv_src_t s_out;
    logic     hit;
    s_out = s_in;
    hit   = 1'b0;
    if (!s_in.rdy) begin
      for (int l = 0; l < CDB_LANES; l++) begin
        if (!hit && cdb_val[l] && (cdb_tag[l] == s_in.tag)) begin
          hit       = 1'b1;
          s_out.rdy = 1'b1;
          s_out.val = cdb_data[l];
        end
      end
    end
    return s_out;
  endfunction

  always_comb begin
    valid_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i] = ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid;
      for (int s = 0; s < NUM_SRCS; s++) begin
        ready_vec[i] = ready_vec[i] & ent_q[i].src[s].rdy;
      end
    end
  end

  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!valid_vec[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  // Ready to allocate comes only from the registered full flag, never from dispatch.
  assign alloc_fire = bus.alloc_val & ~full_q;
  assign disp_fire  = (|ready_vec) & bus.disp_rdy;
  assign alloc_oh   = alloc_fire ? free_oh : '0;
  assign disp_oh    = disp_fire ? grant : '0;

  rsv_age_sel #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_age_sel (
    .clk      (clk),
    .rst      (rst),
    .flush    (bus.flush),
    .alloc_oh (alloc_oh),
    .disp_oh  (disp_oh),
    .ready    (ready_vec),
    .grant    (grant)
  );

  always_comb begin
    for (int s = 0; s < NUM_SRCS; s++) begin
      alloc_src[s].rdy = bus.alloc_src_rdy[s];
      alloc_src[s].tag = bus.alloc_src_tag[s*TAG_W +: TAG_W];
      alloc_src[s].val = bus.alloc_src_val[s*DATA_W +: DATA_W];
    end
  end

  // Flush is applied last so it overrides allocation, dispatch and wakeup.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        for (int s = 0; s < NUM_SRCS; s++) begin
          ent_d[i].src[s] = snoop(ent_q[i].src[s]);
        end
      end
      if (disp_oh[i]) begin
        ent_d[i].valid = 1'b0;
      end
      if (alloc_oh[i]) begin
        ent_d[i].valid   = 1'b1;
        ent_d[i].op      = bus.alloc_op;
        ent_d[i].dst_tag = bus.alloc_dst_tag;
        for (int s = 0; s < NUM_SRCS; s++) begin
          ent_d[i].src[s] = snoop(alloc_src[s]);
        end
      end
      if (bus.flush) begin
        ent_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    if (bus.flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(disp_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(NUM_ENTRIES));
      empty_q <= (count_d == '0);
    end
  end

  // AND-OR payload mux; an all-zero grant yields zero outputs.
  always_comb begin
    sel_op  = '0;
    sel_dst = '0;
    sel_src = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (grant[i]) begin
        sel_op  = sel_op | ent_q[i].op;
        sel_dst = sel_dst | ent_q[i].dst_tag;
        for (int s = 0; s < NUM_SRCS; s++) begin
          sel_src[s*DATA_W +: DATA_W] = sel_src[s*DATA_W +: DATA_W] | ent_q[i].src[s].val;
        end
      end
    end
  end

  always_comb begin
    cdb_dup = 1'b0;
    for (int a = 0; a < CDB_LANES; a++) begin
      for (int b = a + 1; b < CDB_LANES; b++) begin
        if (cdb_val[a] && cdb_val[b] && (cdb_tag[a] == cdb_tag[b])) begin
          cdb_dup = 1'b1;
        end
      end
    end
  end

  assign bus.alloc_rdy    = ~full_q;
  assign bus.disp_val     = |ready_vec;
  assign bus.disp_op      = sel_op;
  assign bus.disp_dst_tag = sel_dst;
  assign bus.disp_src     = sel_src;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;

  a_cdb_tags_unique: assert property (@(posedge clk) disable iff (rst) !cdb_dup);
  a_grant_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(grant));

endmodule

// File: tb/tb_rsv_sched.sv
// Directed bench for rsv_sched: reset, issue, wakeup, bypass, full handling,
// age ordering and flush, each scenario with hand-computed expectations.
module tb_rsv_sched;
  import rsv_pkg::*;

  localparam int NE = 8;
  localparam int CL = 2;
  localparam int NS = 2;
  localparam int TW = RSV_TAG_W;
  localparam int DW = 32;
  localparam int OW = 6;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rsv_sched_if #(.NUM_ENTRIES(NE), .CDB_LANES(CL), .NUM_SRCS(NS), .TAG_W(TW), .DATA_W(DW), .OP_W(OW)) bus ();

  rsv_sched #(.NUM_ENTRIES(NE), .CDB_LANES(CL), .NUM_SRCS(NS), .TAG_W(TW), .DATA_W(DW), .OP_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0;
    bus.alloc_val = 1'b0;
    bus.alloc_op = '0;
    bus.alloc_dst_tag = '0;
    bus.alloc_src_rdy = '0;
    bus.alloc_src_tag = '0;
    bus.alloc_src_val = '0;
    bus.cdb_val = '0;
    bus.cdb_tag = '0;
    bus.cdb_data = '0;
    bus.disp_rdy = 1'b0;
  endtask

  task automatic set_alloc(input logic [OW-1:0] op, input logic [TW-1:0] dst,
                           input logic r0, input logic [TW-1:0] t0, input logic [DW-1:0] v0,
                           input logic r1, input logic [TW-1:0] t1, input logic [DW-1:0] v1);
    bus.alloc_val = 1'b1;
    bus.alloc_op = op;
    bus.alloc_dst_tag = dst;
    bus.alloc_src_rdy = {r1, r0};
    bus.alloc_src_tag = {t1, t0};
    bus.alloc_src_val = {v1, v0};
  endtask

  task automatic set_cdb(input int lane, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    bus.cdb_val[lane] = 1'b1;
    bus.cdb_tag[lane*TW +: TW] = tag;
    bus.cdb_data[lane*DW +: DW] = data;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.alloc_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_alloc_rdy: got %0b expected 1", bus.alloc_rdy); end
    checks++; if (bus.disp_val !== 1'b0) begin errors++; $display("[TB] FAIL reset_disp_val: got %0b expected 0", bus.disp_val); end
    checks++; if (bus.disp_op !== 6'd0) begin errors++; $display("[TB] FAIL reset_disp_op: got %0h expected 0", bus.disp_op); end
    checks++; if (bus.disp_dst_tag !== 5'd0) begin errors++; $display("[TB] FAIL reset_disp_dst: got %0d expected 0", bus.disp_dst_tag); end
    checks++; if (bus.disp_src !== 64'd0) begin errors++; $display("[TB] FAIL reset_disp_src: got %0h expected 0", bus.disp_src); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b expected 0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %0b expected 1", bus.empty); end
  endtask

  task automatic test_basic_issue();
    bus.disp_rdy = 1'b1;
    set_alloc(6'h13, 5'd5, 1'b1, 5'd0, 32'hA, 1'b1, 5'd0, 32'hB);
    tick();
    bus.alloc_val = 1'b0;
    checks++; if (bus.disp_val !== 1'b1) begin errors++; $display("[TB] FAIL basic_disp_val: got %0b expected 1", bus.disp_val); end
    checks++; if (bus.disp_op !== 6'h13) begin errors++; $display("[TB] FAIL basic_disp_op: got %0h expected 13", bus.disp_op); end
    checks++; if (bus.disp_dst_tag !== 5'd5) begin errors++; $display("[TB] FAIL basic_disp_dst: got %0d expected 5", bus.disp_dst_tag); end
    checks++; if (bus.disp_src !== {32'hB, 32'hA}) begin errors++; $display("[TB] FAIL basic_disp_src: got %0h expected b0000000a", bus.disp_src); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("[TB] FAIL basic_count: got %0d expected 1", bus.count); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL basic_empty_busy: got %0b expected 0", bus.empty); end
    tick();
    checks++; if (bus.disp_val !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained_val: got %0b expected 0", bus.disp_val); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL basic_empty_after: got %0b expected 1", bus.empty); end
  endtask

  task automatic test_wakeup_order();
    bus.disp_rdy = 1'b1;
    set_alloc(6'd1, 5'd1, 1'b0, 5'd7, 32'h0, 1'b1, 5'd0, 32'h22);
    tick();
    checks++; if (bus.disp_val !== 1'b0) begin errors++; $display("[TB] FAIL wake_waiting_val: got %0b expected 0", bus.disp_val); end
    set_alloc(6'd2, 5'd2, 1'b1, 5'd0, 32'h33, 1'b1, 5'd0, 32'h44);
    tick();
    bus.alloc_val = 1'b0;
    checks++; if (bus.disp_dst_tag !== 5'd2) begin errors++; $display("[TB] FAIL wake_first_dst: got %0d expected 2", bus.disp_dst_tag); end
    set_cdb(1, 5'd7, 32'h55);
    tick();
    bus.cdb_val = '0;
    checks++; if (bus.disp_val !== 1'b1) begin errors++; $display("[TB] FAIL wake_second_val: got %0b expected 1", bus.disp_val); end
    checks++; if (bus.disp_dst_tag !== 5'd1) begin errors++; $display("[TB] FAIL wake_second_dst: got %0d expected 1", bus.disp_dst_tag); end
    checks++; if (bus.disp_src !== {32'h22, 32'h55}) begin errors++; $display("[TB] FAIL wake_second_src: got %0h expected 2200000055", bus.disp_src); end
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL wake_empty: got %0b expected 1", bus.empty); end
  endtask

  task automatic test_bypass();
    bus.disp_rdy = 1'b0;
    set_alloc(6'd3, 5'd9, 1'b0, 5'd3, 32'h0, 1'b1, 5'd0, 32'h7);
    set_cdb(0, 5'd3, 32'h99);
    tick();
    bus.alloc_val = 1'b0;
    bus.cdb_val = '0;
    checks++; if (bus.disp_val !== 1'b1) begin errors++; $display("[TB] FAIL bypass_val: got %0b expected 1", bus.disp_val); end
    checks++; if (bus.disp_src !== {32'h7, 32'h99}) begin errors++; $display("[TB] FAIL bypass_src: got %0h expected 700000099", bus.disp_src); end
    bus.disp_rdy = 1'b1;
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL bypass_empty: got %0b expected 1", bus.empty); end
    // tag 0 is an ordinary producer id; only the rdy bit marks a source valid
    set_alloc(6'd4, 5'd10, 1'b1, 5'd0, 32'h1, 1'b0, 5'd0, 32'h0);
    tick();
    bus.alloc_val = 1'b0;
    checks++; if (bus.disp_val !== 1'b0) begin errors++; $display("[TB] FAIL tag0_waiting_val: got %0b expected 0", bus.disp_val); end
    set_cdb(1, 5'd0, 32'h1234);
    tick();
    bus.cdb_val = '0;
    checks++; if (bus.disp_src !== {32'h1234, 32'h1}) begin errors++; $display("[TB] FAIL tag0_src: got %0h expected 123400000001", bus.disp_src); end
    tick();
    checks++; if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL tag0_count: got %0d expected 0", bus.count); end
  endtask

  task automatic test_full();
    int exp_dst [8] = '{9, 10, 11, 12, 13, 14, 15, 20};
    bus.disp_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_alloc(OW'(k), TW'(8 + k), 1'b1, 5'd0, DW'(k), 1'b1, 5'd0, DW'(k + 100));
      tick();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL full_flag: got %0b expected 1", bus.full); end
    checks++; if (bus.alloc_rdy !== 1'b0) begin errors++; $display("[TB] FAIL full_alloc_rdy: got %0b expected 0", bus.alloc_rdy); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL full_count: got %0d expected 8", bus.count); end
    set_alloc(6'h3f, 5'd20, 1'b1, 5'd0, 32'h20, 1'b1, 5'd0, 32'h21);
    tick();
    checks++; if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL full_ninth_ignored: got %0d expected 8", bus.count); end
    bus.disp_rdy = 1'b1;
    tick();
    checks++; if (bus.count !== 4'd7) begin errors++; $display("[TB] FAIL full_release_count: got %0d expected 7", bus.count); end
    checks++; if (bus.alloc_rdy !== 1'b1) begin errors++; $display("[TB] FAIL full_release_rdy: got %0b expected 1", bus.alloc_rdy); end
    bus.disp_rdy = 1'b0;
    tick();
    bus.alloc_val = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("[TB] FAIL full_refill_count: got %0d expected 8", bus.count); end
    bus.disp_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.disp_dst_tag !== TW'(exp_dst[k])) begin errors++; $display("[TB] FAIL full_drain_dst[%0d]: got %0d expected %0d", k, bus.disp_dst_tag, exp_dst[k]); end
      tick();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL full_drain_empty: got %0b expected 1", bus.empty); end
  endtask

  task automatic test_age_order();
    int exp_dst [8] = '{4, 5, 6, 7, 16, 17, 18, 19};
    bus.disp_rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) set_alloc(OW'(k), TW'(k), 1'b1, 5'd0, DW'(k), 1'b1, 5'd0, DW'(k));
      else       set_alloc(OW'(k), TW'(k), 1'b0, 5'd9, 32'h0, 1'b1, 5'd0, DW'(k));
      tick();
    end
    bus.alloc_val = 1'b0;
    bus.disp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.disp_dst_tag !== TW'(k)) begin errors++; $display("[TB] FAIL age_first_dst[%0d]: got %0d expected %0d", k, bus.disp_dst_tag, k); end
      tick();
    end
    bus.disp_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_alloc(OW'(k), TW'(16 + k), 1'b1, 5'd0, DW'(k), 1'b1, 5'd0, DW'(k));
      tick();
    end
    bus.alloc_val = 1'b0;
    set_cdb(0, 5'd9, 32'h90);
    tick();
    bus.cdb_val = '0;
    bus.disp_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.disp_dst_tag !== TW'(exp_dst[k])) begin errors++; $display("[TB] FAIL age_order_dst[%0d]: got %0d expected %0d", k, bus.disp_dst_tag, exp_dst[k]); end
      if (k == 0) begin
        checks++; if (bus.disp_src[31:0] !== 32'h90) begin errors++; $display("[TB] FAIL age_woken_src: got %0h expected 90", bus.disp_src[31:0]); end
      end
      tick();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL age_empty: got %0b expected 1", bus.empty); end
  endtask

  task automatic test_flush();
    bus.disp_rdy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 3) set_alloc(OW'(k), TW'(k), 1'b1, 5'd0, DW'(k), 1'b1, 5'd0, DW'(k));
      else        set_alloc(OW'(k), TW'(k), 1'b0, 5'd12, 32'h0, 1'b1, 5'd0, DW'(k));
      tick();
    end
    checks++; if (bus.count !== 4'd5) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d expected 5", bus.count); end
    set_alloc(6'd6, 5'd6, 1'b1, 5'd0, 32'h6, 1'b1, 5'd0, 32'h6);
    bus.disp_rdy = 1'b1;
    tick();
    checks++; if (bus.count !== 4'd5) begin errors++; $display("[TB] FAIL alloc_disp_count: got %0d expected 5", bus.count); end
    checks++; if (bus.disp_dst_tag !== 5'd2) begin errors++; $display("[TB] FAIL alloc_disp_next_dst: got %0d expected 2", bus.disp_dst_tag); end
    set_alloc(6'd7, 5'd7, 1'b1, 5'd0, 32'h7, 1'b1, 5'd0, 32'h7);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.alloc_val = 1'b0;
    bus.disp_rdy = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", bus.count); end
    checks++; if (bus.disp_val !== 1'b0) begin errors++; $display("[TB] FAIL flush_disp_val: got %0b expected 0", bus.disp_val); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.disp_dst_tag !== 5'd0) begin errors++; $display("[TB] FAIL flush_disp_dst: got %0d expected 0", bus.disp_dst_tag); end
    set_cdb(0, 5'd12, 32'hDEAD);
    tick();
    bus.cdb_val = '0;
    checks++; if (bus.disp_val !== 1'b0) begin errors++; $display("[TB] FAIL flush_stale_wake_val: got %0b expected 0", bus.disp_val); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("[TB] FAIL flush_stale_wake_count: got %0d expected 0", bus.count); end
    checks++; if (bus.alloc_rdy !== 1'b1) begin errors++; $display("[TB] FAIL flush_alloc_rdy: got %0b expected 1", bus.alloc_rdy); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup_order();
    test_bypass();
    test_full();
    test_age_order();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
